// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the program ROM and captures the returned word into IF/ID.
// Handles redirect, stall and flush, and halts for good on any fetch address outside the ROM window.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Instruction,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchAddress,
    input  logic                  Jump,
    input  logic [25:0]           JumpIndex,
    input  logic                  JumpRegister,
    input  logic [DATA_WIDTH-1:0] RegisterAddress,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] IF_ID_Instruction,
    output logic [DATA_WIDTH-1:0] IF_ID_PCPlus4,
    output logic                  IF_ID_Valid,
    output logic                  AddressError
);

    // state | meaning
    // RUN   | normal fetch; redirect, stall and flush honoured
    // HALT  | illegal fetch seen; PC frozen, bubbles only, left by reset alone

    typedef enum logic [0:0] {RUN, HALT} state_t;

    localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(4 * (MEMORY_DEPTH - 1));

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_d, instr_d, pcp4_d;
    logic                    valid_d, err_d;
    logic [DATA_WIDTH-1:0]   pc_plus4, j_target, target, candidate, offset;
    logic                    redirect, check_en, fault;

    assign pc_plus4 = PC + DATA_WIDTH'(4);
    assign j_target = {IF_ID_PCPlus4[DATA_WIDTH-1:28], JumpIndex, 2'b00};
    assign redirect = JumpRegister | Jump | BranchTaken;

    always_comb begin
        target = pc_plus4;
        if (JumpRegister)     target = RegisterAddress;
        else if (Jump)        target = j_target;
        else if (BranchTaken) target = BranchAddress;
    end

    // Offset from RESET_PC wraps to a huge value when below the window, so one
    // unsigned compare catches both ends of the window and any PC+4 overflow.
    assign candidate = target;
    assign offset    = candidate - RESET_PC;
    assign check_en  = redirect | ~Stall;
    assign fault     = check_en & ((candidate[1:0] != 2'b00) | (offset > SPAN));

    always_comb begin
        state_d = state_q;
        pc_d    = PC;
        instr_d = IF_ID_Instruction;
        pcp4_d  = IF_ID_PCPlus4;
        valid_d = IF_ID_Valid;
        err_d   = AddressError;
        unique case (state_q)
            RUN: begin
                if (fault) begin
                    err_d   = 1'b1;
                    instr_d = '0;
                    pcp4_d  = '0;
                    valid_d = 1'b0;
                    state_d = HALT;
                end else if (redirect) begin
                    pc_d    = target;
                    instr_d = '0;
                    pcp4_d  = '0;
                    valid_d = 1'b0;
                end else if (Stall) begin
                    if (Flush) begin
                        instr_d = '0;
                        pcp4_d  = '0;
                        valid_d = 1'b0;
                    end
                end else if (Flush) begin
                    pc_d    = pc_plus4;
                    instr_d = '0;
                    pcp4_d  = '0;
                    valid_d = 1'b0;
                end else begin
                    pc_d    = pc_plus4;
                    instr_d = Instruction;
                    pcp4_d  = pc_plus4;
                    valid_d = 1'b1;
                end
            end
            HALT: begin
                err_d   = 1'b1;
                instr_d = '0;
                pcp4_d  = '0;
                valid_d = 1'b0;
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= RUN;
            PC                <= RESET_PC;
            IF_ID_Instruction <= '0;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
            AddressError      <= 1'b0;
        end else begin
            state_q           <= state_d;
            PC                <= pc_d;
            IF_ID_Instruction <= instr_d;
            IF_ID_PCPlus4     <= pcp4_d;
            IF_ID_Valid       <= valid_d;
            AddressError      <= err_d;
        end
    end

endmodule
